// File: rtl/led_pattern_engine_if.sv
// led_pattern_engine_if: mode/control inputs and LED/status outputs of the pattern engine
// Signals: sw (mode select), contin (active-low load/run), hold (pause),
//          led_out (LED bar), tick (step pulse), running (state is RUN).
// master drives the controls, slave is the engine.
interface led_pattern_engine_if #(
  parameter int LED_W = 18
);
  logic [1:0] sw;
  logic contin;
  logic hold;
  logic [LED_W-1:0] led_out;
  logic tick;
  logic running;
  modport master (output sw, contin, hold, input led_out, tick, running);
  modport slave (input sw, contin, hold, output led_out, tick, running);
endinterface

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: divided-clock LED pattern generator with rotate, field-increment and optional bounce modes
// Ports: clk, reset (async, active-high); bus (slave): sw, contin, hold in; led_out, tick, running out.
// Define LED_BOUNCE_EN to turn mode 11 into a bouncing single lit bit instead of a high-field increment.
module led_pattern_engine #(
  parameter int LED_W = 18,
  parameter int TICK_DIV = 50000000,
  parameter int FIELD_W = 4
) (
  input logic clk,
  input logic reset,
  led_pattern_engine_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2;
  localparam int DW = $clog2(TICK_DIV);
  logic [1:0] state, state_nxt, mode;
  logic [DW-1:0] div;
  logic [LED_W-1:0] led, led_nxt, m3_nxt;
  logic tick, running, count, wrap;
  // the divider only advances on RUN cycles that are not being paused
  assign count = state == RUN && !bus.hold;
  assign wrap = count && div == DW'(TICK_DIV - 1);
  // RUN and PAUSE both follow hold directly; IDLE ignores hold
  always_comb state_nxt = state == IDLE ? (bus.contin ? IDLE : RUN) : (bus.hold ? PAUSE : RUN);
`ifdef LED_BOUNCE_EN
  logic dir, onehot, go_right;
  assign onehot = led != '0 && (led & (led - LED_W'(1))) == '0;
  // a bit parked at either end always heads back inward, whatever dir says
  assign go_right = led[LED_W-1] | (dir & ~led[0]);
  assign m3_nxt = !onehot ? LED_W'(1) : go_right ? led >> 1 : led << 1;
  always_ff @(posedge clk or posedge reset)
    if (reset) dir <= 1'b0;
    else if (wrap && mode == 2'b11) dir <= !onehot ? 1'b0 : m3_nxt[LED_W-1] ? 1'b1 : m3_nxt[0] ? 1'b0 : go_right;
`else
  assign m3_nxt = {led[LED_W-1:LED_W-FIELD_W] + FIELD_W'(1), led[LED_W-FIELD_W-1:0]};
`endif
  always_comb
    led_nxt = mode == 2'b00 ? {led[0], led[LED_W-1:1]} :
              mode == 2'b01 ? {led[LED_W-2:0], led[LED_W-1]} :
              mode == 2'b10 ? {led[LED_W-1:FIELD_W], led[FIELD_W-1:0] + FIELD_W'(1)} : m3_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mode <= 2'b00;
      div <= '0;
      led <= LED_W'(1);
      tick <= 1'b0;
      running <= 1'b0;
    end else begin
      state <= state_nxt;
      running <= state_nxt == RUN;
      tick <= wrap;
      if (!bus.contin) mode <= bus.sw;
      if (count) div <= wrap ? '0 : div + DW'(1);
      if (wrap) led <= led_nxt;
    end
  assign bus.led_out = led;
  assign bus.tick = tick;
  assign bus.running = running;
endmodule
